mac_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 2-stage multiply-add pipeline (result = A*B + C) among NREQ requesters. It accepts at most one operation per cycle over per-requester valid/ready handshakes and carries the requester ID through the pipeline. Each result is returned on a single response port with backpressure. It sits between the client blocks and the shared arithmetic resource, and replaces per-client multiply-add instances.

---
 rtl/mac_rr_arbiter_pkg.sv | 18 +
 rtl/mac_rr_arbiter_if.sv | 34 +++
 rtl/mac_rr_arbiter_pipe.sv | 55 +++++
 rtl/mac_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mac_rr_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_rr_arbiter_pkg.sv
// Shared constants and width helpers for the round-robin multiply-add arbiter.
package mac_arb_pkg;

  localparam int unsigned A_W_DEF = 7;
  localparam int unsigned B_W_DEF = 7;
  localparam int unsigned C_W_DEF = 14;
  localparam int unsigned CNT_W   = 16;

  // One extra bit over the wider of product and addend, so A*B + C never truncates.
  function automatic int unsigned calc_r_w(int unsigned a_w, int unsigned b_w, int unsigned c_w);
    return (((a_w + b_w) > c_w) ? (a_w + b_w) : c_w) + 1;
  endfunction

  function automatic int unsigned calc_id_w(int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/mac_rr_arbiter_if.sv
// Requester and response bundle for mac_rr_arbiter; slave side faces the arbiter.
interface mac_rr_arbiter_if
  import mac_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned A_W  = A_W_DEF,
  parameter int unsigned B_W  = B_W_DEF,
  parameter int unsigned C_W  = C_W_DEF
);
  localparam int unsigned R_W  = calc_r_w(A_W, B_W, C_W);
  localparam int unsigned ID_W = calc_id_w(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [NREQ*C_W-1:0] req_c;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [R_W-1:0]      rsp_data;
  logic [CNT_W-1:0]    op_count;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, op_count
  );

endinterface

// File: rtl/mac_rr_arbiter_pipe.sv
// Two-stage multiply-add (A*B + C) with a valid bit and ID tag; both stages shift on i_en.
module mac_pipe #(
  parameter int unsigned A_W  = 7,
  parameter int unsigned B_W  = 7,
  parameter int unsigned C_W  = 14,
  parameter int unsigned ID_W = 2,
  parameter int unsigned R_W  = 15
) (
  input  logic            clk_n,
  input  logic            reset,
  input  logic            i_en,
  input  logic            i_valid,
  input  logic [ID_W-1:0] i_id,
  input  logic [A_W-1:0]  i_a,
  input  logic [B_W-1:0]  i_b,
  input  logic [C_W-1:0]  i_c,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id,
  output logic [R_W-1:0]  o_data
);
  localparam int unsigned P_W = A_W + B_W;

  logic            r_v1;
  logic [ID_W-1:0] r_id1;
  logic [P_W-1:0]  r_prod1;
  logic [C_W-1:0]  r_c1;
  logic            r_v2;
  logic [ID_W-1:0] r_id2;
  logic [R_W-1:0]  r_data2;

  always_ff @(posedge clk_n or posedge reset) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_id1   <= '0;
      r_prod1 <= '0;
      r_c1    <= '0;
      r_v2    <= 1'b0;
      r_id2   <= '0;
      r_data2 <= '0;
    end else if (i_en) begin
      r_v1    <= i_valid;
      r_id1   <= i_id;
      r_prod1 <= P_W'(i_a) * P_W'(i_b);
      r_c1    <= i_c;
      r_v2    <= r_v1;
      r_id2   <= r_id1;
      r_data2 <= R_W'(r_prod1) + R_W'(r_c1);
    end
  end

  assign o_valid = r_v2;
  assign o_id    = r_id2;
  assign o_data  = r_data2;

endmodule

// File: rtl/mac_rr_arbiter.sv
// Round-robin front end sharing one multiply-add pipeline among NREQ requesters.
module mac_rr_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned A_W  = A_W_DEF,
  parameter int unsigned B_W  = B_W_DEF,
  parameter int unsigned C_W  = C_W_DEF
) (
  input logic              clk_n,
  input logic              reset,
  mac_rr_arbiter_if.slave  bus
);
  localparam int unsigned R_W  = calc_r_w(A_W, B_W, C_W);
  localparam int unsigned ID_W = calc_id_w(NREQ);

  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_op_count;

  logic             w_adv;
  logic             w_any;
  logic             w_accept;
  logic [NREQ-1:0]  w_grant;
  logic [ID_W-1:0]  w_gnt_id;
  logic [ID_W-1:0]  w_idx;
  logic [A_W-1:0]   w_a;
  logic [B_W-1:0]   w_b;
  logic [C_W-1:0]   w_c;
  logic             w_rsp_valid;
  logic [ID_W-1:0]  w_rsp_id;
  logic [R_W-1:0]   w_rsp_data;

  assign w_adv = !w_rsp_valid || bus.rsp_ready;

  // First valid requester at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_grant  = '0;
    w_any    = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = ID_W'((32'(r_ptr) + k) % NREQ);
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any          = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gnt_id       = w_idx;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    w_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_grant[i]) begin
        w_a = bus.req_a[i*A_W +: A_W];
        w_b = bus.req_b[i*B_W +: B_W];
        w_c = bus.req_c[i*C_W +: C_W];
      end
    end
  end

  assign w_accept      = w_any && w_adv && !reset;
  assign bus.req_ready = (w_adv && !reset) ? w_grant : '0;

  always_ff @(posedge clk_n or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_ptr <= (w_gnt_id == ID_W'(NREQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
      end
      if (w_rsp_valid && bus.rsp_ready) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  mac_pipe #(
    .A_W  (A_W),
    .B_W  (B_W),
    .C_W  (C_W),
    .ID_W (ID_W),
    .R_W  (R_W)
  ) u_pipe (
    .clk_n   (clk_n),
    .reset   (reset),
    .i_en    (w_adv),
    .i_valid (w_accept),
    .i_id    (w_gnt_id),
    .i_a     (w_a),
    .i_b     (w_b),
    .i_c     (w_c),
    .o_valid (w_rsp_valid),
    .o_id    (w_rsp_id),
    .o_data  (w_rsp_data)
  );

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_id    = w_rsp_id;
  assign bus.rsp_data  = w_rsp_data;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Self-checking bench for mac_rr_arbiter: vector table, hand sequences, random vs model.
module tb_mac_rr_arbiter;
  import mac_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned A_W  = 7;
  localparam int unsigned B_W  = 7;
  localparam int unsigned C_W  = 14;

  logic clk_n = 1'b0;
  logic reset = 1'b1;

  mac_rr_arbiter_if #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .C_W(C_W)) bus ();

  mac_rr_arbiter #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .C_W(C_W)) dut (
    .clk_n (clk_n),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_n = ~clk_n;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_all(int unsigned a, int unsigned b, int unsigned c);
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_a[i*A_W +: A_W] = A_W'(a);
      bus.req_b[i*B_W +: B_W] = B_W'(b);
      bus.req_c[i*C_W +: C_W] = C_W'(c);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_n);
    #1;
  endtask

  // Reference model: pending (not yet presented) op and presented op, with expected results.
  int m_ptr, m_cnt;
  bit m1_v, mo_v;
  int m1_id, m1_res, mo_id, mo_res;

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0;
    m1_v = 0; mo_v = 0;
    m1_id = 0; m1_res = 0; mo_id = 0; mo_res = 0;
  endtask

  task automatic model_cycle();
    bit adv;
    int win, idx, ra, rb, rc;
    logic [NREQ-1:0] exp_rdy;
    #2;
    adv = !mo_v || bus.rsp_ready;
    win = -1;
    if (adv) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        idx = (m_ptr + k) % int'(NREQ);
        if (win < 0 && bus.req_valid[idx]) win = idx;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("rnd_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(mo_v));
    if (mo_v) begin
      chk("rnd_rsp_id", 32'(bus.rsp_id), mo_id);
      chk("rnd_rsp_data", 32'(bus.rsp_data), mo_res);
    end
    chk("rnd_op_count", 32'(bus.op_count), m_cnt);
    ra = 0; rb = 0; rc = 0;
    if (win >= 0) begin
      ra = int'(bus.req_a[win*A_W +: A_W]);
      rb = int'(bus.req_b[win*B_W +: B_W]);
      rc = int'(bus.req_c[win*C_W +: C_W]);
    end
    if (mo_v && bus.rsp_ready) m_cnt = (m_cnt + 1) % 65536;
    if (adv) begin
      mo_v = m1_v; mo_id = m1_id; mo_res = m1_res;
      m1_v = (win >= 0);
      if (win >= 0) begin
        m1_id  = win;
        m1_res = ra * rb + rc;
        m_ptr  = (win + 1) % int'(NREQ);
      end
    end
    next_cycle();
  endtask

  typedef struct {
    logic [3:0]  valid;
    int unsigned a, b, c;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    int unsigned exp_id, exp_data, exp_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int guard;
    tbl[0] = '{4'b0100,   3,   4,     5, 4'b0100, 1'b0, 0,     0, 0};
    tbl[1] = '{4'b0000,   0,   0,     0, 4'b0000, 1'b0, 0,     0, 0};
    tbl[2] = '{4'b1111, 127, 127, 16383, 4'b1000, 1'b1, 2,    17, 0};
    tbl[3] = '{4'b1111,   1,   1,     0, 4'b0001, 1'b0, 0,     0, 1};
    tbl[4] = '{4'b1010,   2,   5,     1, 4'b0010, 1'b1, 3, 32512, 1};
    tbl[5] = '{4'b1001,  10,  10,     0, 4'b1000, 1'b1, 0,     1, 2};
    tbl[6] = '{4'b0000,   0,   0,     0, 4'b0000, 1'b1, 1,    11, 3};
    tbl[7] = '{4'b0000,   0,   0,     0, 4'b0000, 1'b1, 3,   100, 4};
    tbl[8] = '{4'b0000,   0,   0,     0, 4'b0000, 1'b0, 0,     0, 5};

    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    set_all(1, 1, 1);
    #2;
    chk("reset_req_ready", 32'(bus.req_ready), 0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("reset_op_count", 32'(bus.op_count), 0);
    bus.req_valid = '0;
    #10 reset = 1'b0;
    next_cycle();

    for (int r = 0; r < 9; r++) begin
      bus.req_valid = tbl[r].valid;
      set_all(tbl[r].a, tbl[r].b, tbl[r].c);
      #2;
      chk($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].exp_ready));
      chk($sformatf("tbl%0d_rsp_valid", r), 32'(bus.rsp_valid), 32'(tbl[r].exp_rv));
      if (tbl[r].exp_rv) begin
        chk($sformatf("tbl%0d_rsp_id", r), 32'(bus.rsp_id), tbl[r].exp_id);
        chk($sformatf("tbl%0d_rsp_data", r), 32'(bus.rsp_data), tbl[r].exp_data);
      end
      chk($sformatf("tbl%0d_op_count", r), 32'(bus.op_count), tbl[r].exp_cnt);
      next_cycle();
    end

    // Backpressure with two operations in flight.
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_a[i*A_W +: A_W] = A_W'(i + 1);
      bus.req_b[i*B_W +: B_W] = B_W'(i + 2);
      bus.req_c[i*C_W +: C_W] = C_W'(i * 100);
    end
    bus.req_valid = 4'b1111;
    #2 chk("bp_grant0", 32'(bus.req_ready), 32'h1);
    next_cycle();
    #2 chk("bp_grant1", 32'(bus.req_ready), 32'h2);
    chk("bp_pre_valid", 32'(bus.rsp_valid), 0);
    next_cycle();
    bus.rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #2;
      chk("bp_stall_ready", 32'(bus.req_ready), 0);
      chk("bp_stall_valid", 32'(bus.rsp_valid), 1);
      chk("bp_stall_id", 32'(bus.rsp_id), 0);
      chk("bp_stall_data", 32'(bus.rsp_data), 2);
      next_cycle();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    #2;
    chk("bp_rel0_id", 32'(bus.rsp_id), 0);
    chk("bp_rel0_data", 32'(bus.rsp_data), 2);
    next_cycle();
    #2;
    chk("bp_rel1_valid", 32'(bus.rsp_valid), 1);
    chk("bp_rel1_id", 32'(bus.rsp_id), 1);
    chk("bp_rel1_data", 32'(bus.rsp_data), 106);
    next_cycle();
    #2;
    chk("bp_drain_valid", 32'(bus.rsp_valid), 0);
    chk("bp_op_count", 32'(bus.op_count), 7);

    // Asynchronous reset with a response on the port and ptr away from zero.
    bus.req_valid = 4'b1111;
    #1 chk("rst_pre_grant", 32'(bus.req_ready), 32'h4);
    next_cycle();
    bus.req_valid = '0;
    next_cycle();
    #1;
    chk("rst_pre_valid", 32'(bus.rsp_valid), 1);
    chk("rst_pre_data", 32'(bus.rsp_data), 212);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(bus.rsp_valid), 0);
    chk("rst_async_id", 32'(bus.rsp_id), 0);
    chk("rst_async_data", 32'(bus.rsp_data), 0);
    chk("rst_async_count", 32'(bus.op_count), 0);
    #1 reset = 1'b0;
    bus.req_valid = 4'b1010;
    #1 chk("rst_first_grant", 32'(bus.req_ready), 32'h2);
    next_cycle();

    bus.req_valid = '0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    next_cycle();

    // Randomized traffic with occasional backpressure.
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(NREQ); i++) begin
        bus.req_a[i*A_W +: A_W] = ($urandom_range(0, 7) == 0) ? 7'd127 : A_W'($urandom);
        bus.req_b[i*B_W +: B_W] = ($urandom_range(0, 7) == 0) ? 7'd127 : B_W'($urandom);
        bus.req_c[i*C_W +: C_W] = ($urandom_range(0, 7) == 0) ? 14'h3fff : C_W'($urandom);
      end
      model_cycle();
    end

    // Full-throughput run up to the op_count wrap.
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    guard = 0;
    while (m_cnt != 65535 && guard < 70000) begin
      set_all($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 16383));
      model_cycle();
      guard++;
    end
    #1 chk("wrap_reach", 32'(bus.op_count), 65535);
    chk("wrap_rsp_valid", 32'(bus.rsp_valid), 1);
    next_cycle();
    #1 chk("wrap_zero", 32'(bus.op_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
